// File: rtl/sort_pkg.sv
// Shared definitions for the sequential 8-word bitonic sorter.
//   N         : words per batch (the network below is built for 8 only)
//   LOG2N     : index width into the batch buffer
//   STAGES    : number of network stages for N=8
//   state_t   : controller states LOAD / SORT / DRAIN
//   stage_t   : one (k,j) pair of the bitonic network
//   STAGE_TBL : stage pairs in execution order
package sort_pkg;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int STAGES = 6;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] k;
    logic [3:0] j;
  } stage_t;

  localparam stage_t STAGE_TBL [0:STAGES-1] = '{
    '{k: 4'd2, j: 4'd1},
    '{k: 4'd4, j: 4'd2},
    '{k: 4'd4, j: 4'd1},
    '{k: 4'd8, j: 4'd4},
    '{k: 4'd8, j: 4'd2},
    '{k: 4'd8, j: 4'd1}
  };

endpackage

// File: rtl/bitonic_cmp_exch.sv
// Combinational compare-exchange element.
//   a, b   : unsigned input words (a belongs to the lower index)
//   dir    : 0 = ascending (min to lo), 1 = descending (max to lo)
//   lo, hi : words for the lower and higher index
module bitonic_cmp_exch #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dir,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  // Equal words never swap, so either direction leaves them in place.
  assign swap = dir ? (a < b) : (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_sort_seq_ctrl.sv
// Sequential bitonic sorter: loads 8 unsigned words, sorts them in place over
// 6 cycles (one network stage per cycle) and drains them in nondecreasing order.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data is the offered word
//   out_valid/out_ready : output handshake, out_data is the sorted word
//   out_last            : out_data is the final word of the batch
//   busy                : high while sorting or draining
module bitonic_sort_seq_ctrl
  import sort_pkg::LOG2N, sort_pkg::STAGES, sort_pkg::state_t, sort_pkg::stage_t,
         sort_pkg::STAGE_TBL, sort_pkg::LOAD, sort_pkg::SORT, sort_pkg::DRAIN;
#(
  parameter int WIDTH = 4,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int NCMP = N / 2;

  state_t           state;
  state_t           state_nxt;
  logic [LOG2N-1:0] wr_idx;
  logic [LOG2N-1:0] rd_idx;
  logic [2:0]       stg;

  logic [WIDTH-1:0] mem     [N];
  logic [WIDTH-1:0] mem_nxt [N];

  stage_t           st;
  logic [LOG2N-1:0] lo_idx [NCMP];
  logic [LOG2N-1:0] hi_idx [NCMP];
  logic [NCMP-1:0]  dir;
  logic [WIDTH-1:0] cx_lo  [NCMP];
  logic [WIDTH-1:0] cx_hi  [NCMP];

  logic load_acc;
  logic drain_acc;

  assign load_acc  = (state == LOAD) && in_valid;
  assign drain_acc = (state == DRAIN) && out_ready;

  // Outputs depend on state only, so in_valid never reaches out_valid combinationally.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);
  assign out_last  = out_valid && (rd_idx == LOG2N'(N - 1));
  assign out_data  = out_valid ? mem[rd_idx] : '0;

  // Pair selection: lower index is the pair number with a 0 inserted at bit log2(j).
  always_comb begin
    logic [1:0] pp;
    pp = '0;
    st = (stg < 3'(STAGES)) ? STAGE_TBL[stg] : STAGE_TBL[0];
    for (int p = 0; p < NCMP; p++) begin
      pp = 2'(p);
      case (st.j)
        4'd1:    lo_idx[p] = {pp, 1'b0};
        4'd2:    lo_idx[p] = {pp[1], 1'b0, pp[0]};
        default: lo_idx[p] = {1'b0, pp};
      endcase
      hi_idx[p] = lo_idx[p] | st.j[LOG2N-1:0];
      dir[p]    = |({1'b0, lo_idx[p]} & st.k);
    end
  end

  for (genvar g = 0; g < NCMP; g++) begin : g_cx
    bitonic_cmp_exch #(
      .WIDTH(WIDTH)
    ) u_cx (
      .a  (mem[lo_idx[g]]),
      .b  (mem[hi_idx[g]]),
      .dir(dir[g]),
      .lo (cx_lo[g]),
      .hi (cx_hi[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mem_nxt[i] = mem[i];
    end
    for (int p = 0; p < NCMP; p++) begin
      mem_nxt[lo_idx[p]] = cx_lo[p];
      mem_nxt[hi_idx[p]] = cx_hi[p];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_acc && (wr_idx == LOG2N'(N - 1))) state_nxt = SORT;
      SORT:    if (stg == 3'(STAGES - 1)) state_nxt = DRAIN;
      DRAIN:   if (drain_acc && (rd_idx == LOG2N'(N - 1))) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Control state: a reset discards any partial or in-flight batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      stg    <= '0;
    end else begin
      state <= state_nxt;
      if (load_acc) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (state == SORT) begin
        stg <= (stg == 3'(STAGES - 1)) ? 3'd0 : stg + 3'd1;
      end
      // rd_idx wraps 7->0 on the final handshake, ready for the next batch.
      if (drain_acc) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Batch buffer: data only, no reset.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem[wr_idx] <= in_data;
    end else if (state == SORT) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= mem_nxt[i];
      end
    end
  end

endmodule
